// File: rtl/m6809_pkg.sv
// Shared definitions for the 6809 E/Q clock generator with MRDY stretch.
// Phase encoding is {E,Q}, so the phase register drives the CPU clocks directly.
package m6809_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } phase_t;

    // Default forced-release limit, in held clkin cycles.
    localparam int unsigned MAX_STRETCH_DEF = 15;

    // Stretch counter width; the counter saturates instead of wrapping.
    localparam int unsigned STRETCH_CNT_W = 8;

    function automatic logic [STRETCH_CNT_W-1:0] sat_inc(input logic [STRETCH_CNT_W-1:0] v);
        return (v == {STRETCH_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/m6809_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
// Reset value is a parameter so an idle-high signal can come out of reset inactive.
module m6809_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clkin,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw level through two flops; both load RST_VAL in reset.
    always_ff @(posedge clkin) begin
        if (!rst_b) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage shift; blocking would collapse it to one flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/m6809_clkgen_stretch.sv
// 6809 E/Q clock generator, one quarter E cycle per clkin, with MRDY stretch of
// the E-high/Q-low phase. Optional watchdog: define M6809_STRETCH_TIMEOUT_EN to
// force release after MAX_STRETCH held cycles; otherwise a stretch may last forever.
module m6809_clkgen_stretch
    import m6809_pkg::*;
#(
    parameter int unsigned MAX_STRETCH = MAX_STRETCH_DEF
) (
    input  logic clkin,
    input  logic rst_b,
    input  logic en,
    input  logic sys_mrdy,
    output logic eclk,
    output logic qclk,
    output logic cyc_start,
    output logic stretching,
    output logic timeout_err
);

    localparam logic [STRETCH_CNT_W-1:0] MAX_LIM = MAX_STRETCH[STRETCH_CNT_W-1:0];

`ifdef M6809_STRETCH_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    phase_t                   phase;
    logic [STRETCH_CNT_W-1:0] stretch_cnt;
    logic                     mrdy_s;
    logic                     expire;

    // NOTE: the synchroniser resets to 1 (ready) so a reset never looks like a pending stretch request.
    m6809_sync2 #(
        .RST_VAL(1'b1)
    ) u_mrdy_sync (
        .clkin(clkin),
        .rst_b(rst_b),
        .d    (sys_mrdy),
        .q    (mrdy_s)
    );

    // Watchdog trips once the held count reaches the limit; folds to 0 when disabled.
    assign expire = TIMEOUT_EN && (stretch_cnt >= MAX_LIM);

    // E and Q are the phase register bits themselves, so they are glitch-free.
    assign eclk = phase[1];
    assign qclk = phase[0];

    // Phase sequencer with MRDY hold in PH_10; status pulses are registered alongside.
    always_ff @(posedge clkin) begin
        // NOTE: reset is synchronous, so rst_b is tested inside the clocked block, not in the sensitivity list.
        if (!rst_b || !en) begin
            phase       <= PH_00;
            cyc_start   <= 1'b0;
            stretching  <= 1'b0;
            timeout_err <= 1'b0;
            stretch_cnt <= '0;
        end else begin
            cyc_start   <= 1'b0;
            stretching  <= 1'b0;
            timeout_err <= 1'b0;
            case (phase)
                PH_00: begin
                    phase     <= PH_01;
                    cyc_start <= 1'b1;
                end
                PH_01: phase <= PH_11;
                PH_11: begin
                    phase       <= PH_10;
                    stretch_cnt <= '0;
                end
                PH_10: begin
                    if (mrdy_s) begin
                        phase <= PH_00;
                    end else if (expire) begin
                        phase       <= PH_00;
                        timeout_err <= 1'b1;
                    end else begin
                        stretching  <= 1'b1;
                        stretch_cnt <= sat_inc(stretch_cnt);
                    end
                end
                default: phase <= PH_00;
            endcase
        end
    end

endmodule
